sha256_compress: RTL and testbench

Downstream consumer of the message schedule stage. It accepts the 64 schedule words W[0..63] as a 32-bit stream, one word per accepted beat, and performs one SHA-256 compression round per accepted word. After round 63 it adds the working variables to the chaining value and presents a 256-bit digest. It holds the 64-entry K constant ROM and the standard initial hash value H0..H7 internally.

---
 rtl/sha256_compress.sv | 180 ++++++++++++++++++
 tb/tb_sha256_compress.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - SHA-256 compression engine fed by a schedule word stream
//
// Purpose: performs one SHA-256 round per accepted schedule word W[0..63].
// After the last round, it adds the working variables to the starting hash.
// It registers the result as a 256-bit digest. The K constant table and the
// standard IV are held internally.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-low
//   start        one-cycle pulse that begins a new block (honoured in IDLE/DONE)
//   w_in         schedule word W[t], presented in order t=0..63
//   w_valid      w_in is valid this cycle
//   w_ready      engine accepts w_in this cycle (transfer = w_valid & w_ready)
//   digest       {H0..H7}, H0 in bits [255:224]
//   digest_valid digest is final and stable
//   busy         engine is in ROUND or FINAL
//
// Parameter CHAIN: 0 starts every block from the IV; 1 starts each block from
// the previous digest (the IV is restored only by reset).
module sha256_compress #(
  parameter int CHAIN = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  w_in,
  input  logic         w_valid,
  output logic         w_ready,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [5:0]   t;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [255:0] chain;
  logic [255:0] h_start;
  logic [255:0] h_sum;
  logic         beat;
  logic         launch;

  logic [31:0]  sigma1, ch, t1, sigma0, maj, t2;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    w_ready    = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = ROUND;
        end
      end
      ROUND: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (w_valid && (t == 6'd63)) begin
          state_next = FINAL;
        end
      end
      FINAL: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign beat   = w_valid && w_ready;
  assign launch = start && ((state == IDLE) || (state == DONE));

  // The chaining register is untouched while a block runs, so it also serves
  // as the feed-forward operand in FINAL.
  assign h_start = (CHAIN != 0) ? chain : IV;

  // One round of the compression function
  assign sigma1 = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
  assign ch     = (e & f) ^ (~e & g);
  assign t1     = h + sigma1 + ch + K[t] + w_in;
  assign sigma0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
  assign maj    = (a & b) ^ (a & c) ^ (b & c);
  assign t2     = sigma0 + maj;

  // Feed-forward addition of the working variables
  assign h_sum = {
    h_start[255:224] + a, h_start[223:192] + b,
    h_start[191:160] + c, h_start[159:128] + d,
    h_start[127:96]  + e, h_start[95:64]   + f,
    h_start[63:32]   + g, h_start[31:0]    + h
  };

  always_ff @(posedge clk) begin
    if (!rst) begin
      t            <= 6'd0;
      a            <= 32'd0;
      b            <= 32'd0;
      c            <= 32'd0;
      d            <= 32'd0;
      e            <= 32'd0;
      f            <= 32'd0;
      g            <= 32'd0;
      h            <= 32'd0;
      digest       <= 256'd0;
      digest_valid <= 1'b0;
      chain        <= IV;
    end else if (launch) begin
      t            <= 6'd0;
      a            <= h_start[255:224];
      b            <= h_start[223:192];
      c            <= h_start[191:160];
      d            <= h_start[159:128];
      e            <= h_start[127:96];
      f            <= h_start[95:64];
      g            <= h_start[63:32];
      h            <= h_start[31:0];
      digest_valid <= 1'b0;
    end else if (beat) begin
      // t wraps to 0 on the last word; it is reloaded on the next start anyway.
      t <= t + 6'd1;
      h <= g;
      g <= f;
      f <= e;
      e <= d + t1;
      d <= c;
      c <= b;
      b <= a;
      a <= t1 + t2;
    end else if (state == FINAL) begin
      digest       <= h_sum;
      chain        <= h_sum;
      digest_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// tb/tb_sha256_compress.sv - directed self-checking bench for sha256_compress
module tb_sha256_compress;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ZERO_DIG =
    256'h709e80c88487a2411e1ee4dfb9f22a861492d20c4765150c0c794abd70f8147c;

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  w_in;
  logic         w_valid;
  logic         w_ready0, w_ready1;
  logic [255:0] dig0, dig1;
  logic         dv0, dv1;
  logic         busy0, busy1;

  always #5 clk = ~clk;

  sha256_compress #(.CHAIN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .w_in(w_in), .w_valid(w_valid),
    .w_ready(w_ready0), .digest(dig0), .digest_valid(dv0), .busy(busy0)
  );

  sha256_compress #(.CHAIN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .w_in(w_in), .w_valid(w_valid),
    .w_ready(w_ready1), .digest(dig1), .digest_valid(dv1), .busy(busy1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] msg   [16];
  logic [31:0] sched [64];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Single padded block for a 24-bit message: word 0 holds the bytes plus the
  // 0x80 pad byte, word 15 holds the bit length.
  task automatic load_msg(input logic [31:0] w0);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0]  = w0;
    msg[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) sched[i] = msg[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(sched[i-15], 7) ^ rotr(sched[i-15], 18) ^ (sched[i-15] >> 3);
      s1 = rotr(sched[i-2], 17) ^ rotr(sched[i-2], 19) ^ (sched[i-2] >> 10);
      sched[i] = s1 + sched[i-7] + s0 + sched[i-16];
    end
  endtask

  // Reference compression of the current schedule starting from hin.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin);
    logic [31:0]  hh [8];
    logic [31:0]  v  [8];
    logic [31:0]  x1, x2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) begin
      hh[i] = hin[255 - 32*i -: 32];
      v[i]  = hh[i];
    end
    for (int r = 0; r < 64; r++) begin
      x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[r] + sched[r];
      x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
    end
    res = 256'd0;
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hh[i] + v[i];
    return res;
  endfunction

  // Called just after a clock edge. lat counts edges from the start edge
  // (inclusive) through the edge that raises digest_valid.
  task automatic run_block(input int stop_after, input int gap_pct, input bit spam,
                           output int beats, output int lat);
    int idx;
    int cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    // A word offered with start must not be taken.
    start   = 1'b1;
    w_valid = 1'b1;
    w_in    = 32'hdeadbeef;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    check("start_clears_valid", 256'(dv0), 256'd0);
    check("busy_after_start", 256'(busy0), 256'd1);
    while (idx < stop_after && cyc < 1000) begin
      w_in    = sched[idx];
      w_valid = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
      start   = spam ? ($urandom_range(1) == 1) : 1'b0;
      acc     = w_valid && w_ready0;
      @(posedge clk); #1;
      lat++;
      cyc++;
      if (acc) idx++;
    end
    start = 1'b0;
    beats = idx;
    if (stop_after < 64) begin
      w_valid = 1'b0;
      return;
    end
    // Keep offering junk words: none may be accepted after W[63].
    w_valid = 1'b1;
    w_in    = 32'hffffffff;
    while (!dv0 && cyc < 1000) begin
      if (w_ready0) beats++;
      @(posedge clk); #1;
      lat++;
      cyc++;
    end
    w_valid = 1'b0;
    check("done_in_budget", 256'(dv0), 256'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int beats;
    int lat;
    logic [255:0] exp1;

    rst = 1'b0; start = 1'b0; w_valid = 1'b0; w_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digest0", dig0, 256'd0);
    check("rst_digest1", dig1, 256'd0);
    check("rst_valid", 256'(dv0), 256'd0);
    check("rst_w_ready", 256'(w_ready0), 256'd0);
    check("rst_busy", 256'(busy0), 256'd0);
    rst = 1'b1;

    // w_valid in IDLE is ignored
    w_valid = 1'b1; w_in = 32'h12345678;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_w_ready", 256'(w_ready0), 256'd0);
      check("idle_busy", 256'(busy1), 256'd0);
    end
    w_valid = 1'b0;

    // "abc", no gaps
    load_msg(32'h61626380);
    run_block(64, 0, 1'b0, beats, lat);
    check("abc_beats", 256'(beats), 256'd64);
    check("abc_latency", 256'(lat), 256'd66);
    check("abc_digest0", dig0, ABC_DIG);
    check("abc_digest1", dig1, ABC_DIG);
    check("abc_valid1", 256'(dv1), 256'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold_digest", dig0, ABC_DIG);
    check("done_hold_valid", 256'(dv0), 256'd1);
    check("done_busy", 256'(busy0), 256'd0);

    // "abc" again with ~50% gaps, back-to-back from DONE
    exp1 = ref_compress(ABC_DIG);
    run_block(64, 50, 1'b0, beats, lat);
    check("gap_beats", 256'(beats), 256'd64);
    check("gap_digest0", dig0, ABC_DIG);
    check("chain_digest1", dig1, exp1);

    // Reset mid-block after 30 words
    run_block(30, 20, 1'b0, beats, lat);
    check("partial_beats", 256'(beats), 256'd30);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_digest0", dig0, 256'd0);
    check("midrst_digest1", dig1, 256'd0);
    check("midrst_valid", 256'(dv1), 256'd0);
    check("midrst_w_ready", 256'(w_ready0), 256'd0);
    check("midrst_busy", 256'(busy0), 256'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle_w_ready", 256'(w_ready1), 256'd0);
    check("post_rst_idle_busy", 256'(busy1), 256'd0);

    // Rerun "abc" with start pulses sprinkled through ROUND
    run_block(64, 30, 1'b1, beats, lat);
    check("spam_beats", 256'(beats), 256'd64);
    check("spam_digest0", dig0, ABC_DIG);
    check("rerun_digest1", dig1, ABC_DIG);

    // Three zero bytes; the chained instance continues from the abc digest
    load_msg(32'h00000080);
    exp1 = ref_compress(ABC_DIG);
    run_block(64, 0, 1'b0, beats, lat);
    check("zero_latency", 256'(lat), 256'd66);
    check("zero_digest0", dig0, ZERO_DIG);
    check("zero_chain_digest1", dig1, exp1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
